// File: rtl/idu_issue_ctrl.sv
// idu_issue_ctrl
// Scoreboard-based issue controller sitting between the IF/ID and ID/EX
// registers. Per-register in-flight counters track GPR and CSR writes from
// issue until write-back releases them. The pipeline has no forwarding, so
// any source still in flight blocks issue, as does a destination whose
// counter is saturated. A flush kills the ID/EX slot and hands its
// allocation back in the same edge.
module idu_issue_ctrl #(
  parameter int NR_GPR = 32,
  parameter int NR_CSR = 8,
  parameter int CNT_W  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IFU_o_valid,
  input  logic [4:0] IDU_i_rs1,
  input  logic [4:0] IDU_i_rs2,
  input  logic       IDU_i_rs1_used,
  input  logic       IDU_i_rs2_used,
  input  logic [4:0] IDU_i_rd,
  input  logic       IDU_i_write_gpr,
  input  logic [2:0] IDU_i_csr_rs,
  input  logic [2:0] IDU_i_csr_rd,
  input  logic       IDU_i_csr_read,
  input  logic       IDU_i_write_csr,
  input  logic       EXU_i_ready,
  input  logic       EXU_i_flush,
  input  logic       WB_i_release,
  input  logic [4:0] WB_i_rd,
  input  logic       WB_i_gpr_alloc,
  input  logic [2:0] WB_i_csr_rd,
  input  logic       WB_i_csr_alloc,
  output logic       IDU_o_ready,
  output logic       IDU_o_issue,
  output logic       IDU_o_valid,
  output logic       IDU_o_stall,
  output logic       IDU_o_busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Counter step: one optional increment and up to two decrements.
  // Out-of-range results are a protocol violation upstream; the counter
  // simply wraps and the environment is expected to flag it.
  function automatic logic [CNT_W-1:0] cnt_next(
    input logic [CNT_W-1:0] cur,
    input logic             inc,
    input logic             dec_a,
    input logic             dec_b
  );
    logic [CNT_W-1:0] r;
    r = cur;
    if (inc) begin
      r = r + CNT_ONE;
    end else begin
      r = r;
    end
    if (dec_a) begin
      r = r - CNT_ONE;
    end else begin
      r = r;
    end
    if (dec_b) begin
      r = r - CNT_ONE;
    end else begin
      r = r;
    end
    return r;
  endfunction

  // Scoreboard state
  logic [NR_GPR-1:0][CNT_W-1:0] gcnt_q, gcnt_d;
  logic [NR_CSR-1:0][CNT_W-1:0] ccnt_q, ccnt_d;

  // ID/EX slot: valid bit plus the allocations its instruction holds
  logic       valid_q, valid_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_galloc_q, ex_galloc_d;
  logic [2:0] ex_csr_q, ex_csr_d;
  logic       ex_calloc_q, ex_calloc_d;

  // Combinational hazard / handshake terms
  logic raw_s, sat_s, slot_free_s, issue_s;
  logic rs1_haz_s, rs2_haz_s, csr_haz_s;
  logic gpr_sat_s, csr_sat_s;

  // Per-index increment / decrement strobes
  logic [NR_GPR-1:0] gpr_inc_s, gpr_rel_s, gpr_kill_s;
  logic [NR_CSR-1:0] csr_inc_s, csr_rel_s, csr_kill_s;

  // Hazard detection against the registered counters and issue decision
  always_comb begin
    rs1_haz_s   = IDU_i_rs1_used & (IDU_i_rs1 != 5'd0) & (gcnt_q[IDU_i_rs1] != CNT_ZERO);
    rs2_haz_s   = IDU_i_rs2_used & (IDU_i_rs2 != 5'd0) & (gcnt_q[IDU_i_rs2] != CNT_ZERO);
    csr_haz_s   = IDU_i_csr_read & (ccnt_q[IDU_i_csr_rs] != CNT_ZERO);
    raw_s       = rs1_haz_s | rs2_haz_s | csr_haz_s;
    gpr_sat_s   = IDU_i_write_gpr & (IDU_i_rd != 5'd0) & (gcnt_q[IDU_i_rd] == CNT_MAX);
    csr_sat_s   = IDU_i_write_csr & (ccnt_q[IDU_i_csr_rd] == CNT_MAX);
    sat_s       = gpr_sat_s | csr_sat_s;
    slot_free_s = ~valid_q | EXU_i_ready;
    issue_s     = IFU_o_valid & ~raw_s & ~sat_s & slot_free_s & ~EXU_i_flush;
  end

  // Decode which GPR counters move this cycle; x0 is never allocated
  always_comb begin
    gpr_inc_s  = {NR_GPR{1'b0}};
    gpr_rel_s  = {NR_GPR{1'b0}};
    gpr_kill_s = {NR_GPR{1'b0}};
    for (int i = 1; i < NR_GPR; i++) begin
      gpr_inc_s[i]  = issue_s & IDU_i_write_gpr & (IDU_i_rd == 5'(i));
      gpr_rel_s[i]  = WB_i_release & WB_i_gpr_alloc & (WB_i_rd == 5'(i));
      gpr_kill_s[i] = EXU_i_flush & valid_q & ex_galloc_q & (ex_rd_q == 5'(i));
    end
  end

  // Decode which CSR counters move this cycle
  always_comb begin
    csr_inc_s  = {NR_CSR{1'b0}};
    csr_rel_s  = {NR_CSR{1'b0}};
    csr_kill_s = {NR_CSR{1'b0}};
    for (int i = 0; i < NR_CSR; i++) begin
      csr_inc_s[i]  = issue_s & IDU_i_write_csr & (IDU_i_csr_rd == 3'(i));
      csr_rel_s[i]  = WB_i_release & WB_i_csr_alloc & (WB_i_csr_rd == 3'(i));
      csr_kill_s[i] = EXU_i_flush & valid_q & ex_calloc_q & (ex_csr_q == 3'(i));
    end
  end

  // Next-state of every scoreboard counter
  always_comb begin
    gcnt_d    = gcnt_q;
    gcnt_d[0] = CNT_ZERO;
    for (int i = 1; i < NR_GPR; i++) begin
      gcnt_d[i] = cnt_next(gcnt_q[i], gpr_inc_s[i], gpr_rel_s[i], gpr_kill_s[i]);
    end
    ccnt_d = ccnt_q;
    for (int i = 0; i < NR_CSR; i++) begin
      ccnt_d[i] = cnt_next(ccnt_q[i], csr_inc_s[i], csr_rel_s[i], csr_kill_s[i]);
    end
  end

  // ID/EX valid: flush kills, a free slot takes the issue, otherwise hold
  always_comb begin
    if (EXU_i_flush) begin
      valid_d = 1'b0;
    end else if (slot_free_s) begin
      valid_d = issue_s;
    end else begin
      valid_d = valid_q;
    end
  end

  // ID/EX allocation record loads together with the ID/EX register
  always_comb begin
    if (issue_s) begin
      ex_rd_d     = IDU_i_rd;
      ex_galloc_d = IDU_i_write_gpr & (IDU_i_rd != 5'd0);
      ex_csr_d    = IDU_i_csr_rd;
      ex_calloc_d = IDU_i_write_csr;
    end else begin
      ex_rd_d     = ex_rd_q;
      ex_galloc_d = ex_galloc_q;
      ex_csr_d    = ex_csr_q;
      ex_calloc_d = ex_calloc_q;
    end
  end

  // Scoreboard counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt_q <= {(NR_GPR*CNT_W){1'b0}};
      ccnt_q <= {(NR_CSR*CNT_W){1'b0}};
    end else begin
      gcnt_q <= gcnt_d;
      ccnt_q <= ccnt_d;
    end
  end

  // ID/EX slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      ex_rd_q     <= 5'd0;
      ex_galloc_q <= 1'b0;
      ex_csr_q    <= 3'd0;
      ex_calloc_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_galloc_q <= ex_galloc_d;
      ex_csr_q    <= ex_csr_d;
      ex_calloc_q <= ex_calloc_d;
    end
  end

  // Output mapping
  always_comb begin
    IDU_o_issue = issue_s;
    IDU_o_ready = issue_s | ~IFU_o_valid | EXU_i_flush;
    IDU_o_stall = IFU_o_valid & ~issue_s & ~EXU_i_flush;
    IDU_o_valid = valid_q;
    IDU_o_busy  = (|gcnt_q) | (|ccnt_q);
  end

endmodule

// File: tb/tb_idu_issue_ctrl.sv
// tb_idu_issue_ctrl
// Randomized and directed stimulus against a behavioural scoreboard model
// built from integer counters and a queue of instructions past EX.
module tb_idu_issue_ctrl;

  localparam int MAXC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       IFU_o_valid;
  logic [4:0] IDU_i_rs1, IDU_i_rs2, IDU_i_rd;
  logic       IDU_i_rs1_used, IDU_i_rs2_used, IDU_i_write_gpr;
  logic [2:0] IDU_i_csr_rs, IDU_i_csr_rd;
  logic       IDU_i_csr_read, IDU_i_write_csr;
  logic       EXU_i_ready, EXU_i_flush;
  logic       WB_i_release;
  logic [4:0] WB_i_rd;
  logic       WB_i_gpr_alloc;
  logic [2:0] WB_i_csr_rd;
  logic       WB_i_csr_alloc;
  logic       IDU_o_ready, IDU_o_issue, IDU_o_valid, IDU_o_stall, IDU_o_busy;

  idu_issue_ctrl dut (
    .clk(clk), .rst(rst), .IFU_o_valid(IFU_o_valid),
    .IDU_i_rs1(IDU_i_rs1), .IDU_i_rs2(IDU_i_rs2),
    .IDU_i_rs1_used(IDU_i_rs1_used), .IDU_i_rs2_used(IDU_i_rs2_used),
    .IDU_i_rd(IDU_i_rd), .IDU_i_write_gpr(IDU_i_write_gpr),
    .IDU_i_csr_rs(IDU_i_csr_rs), .IDU_i_csr_rd(IDU_i_csr_rd),
    .IDU_i_csr_read(IDU_i_csr_read), .IDU_i_write_csr(IDU_i_write_csr),
    .EXU_i_ready(EXU_i_ready), .EXU_i_flush(EXU_i_flush),
    .WB_i_release(WB_i_release), .WB_i_rd(WB_i_rd),
    .WB_i_gpr_alloc(WB_i_gpr_alloc), .WB_i_csr_rd(WB_i_csr_rd),
    .WB_i_csr_alloc(WB_i_csr_alloc),
    .IDU_o_ready(IDU_o_ready), .IDU_o_issue(IDU_o_issue),
    .IDU_o_valid(IDU_o_valid), .IDU_o_stall(IDU_o_stall),
    .IDU_o_busy(IDU_o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rd;
    bit ga;
    int csr;
    bit ca;
  } ins_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   gm[32];
  int   cm[8];
  bit   vm;
  ins_t slot_m;
  ins_t wbq[$];
  int   s_issue, s_stall, s_ready;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // literal pin on both the model counter and the DUT counter
  task automatic lit_g(input string name, input int k, input int exp);
    chk({name, "_model"}, gm[k], exp);
    chk({name, "_dut"}, int'(dut.gcnt_q[k]), exp);
  endtask

  task automatic set_ins(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit wg, input int crs, input bit cr,
                         input int crd, input bit wc);
    IFU_o_valid     = v;
    IDU_i_rs1       = 5'(rs1);
    IDU_i_rs1_used  = u1;
    IDU_i_rs2       = 5'(rs2);
    IDU_i_rs2_used  = u2;
    IDU_i_rd        = 5'(rd);
    IDU_i_write_gpr = wg;
    IDU_i_csr_rs    = 3'(crs);
    IDU_i_csr_read  = cr;
    IDU_i_csr_rd    = 3'(crd);
    IDU_i_write_csr = wc;
  endtask

  // one cycle: drive the release, compare at negedge, advance the model at posedge
  task automatic step(input bit rel);
    bit e_raw, e_sat, e_free, e_issue, e_ready, e_stall, e_busy;
    int bad;
    ins_t r;
    if (rel && wbq.size() > 0) begin
      WB_i_release   = 1'b1;
      WB_i_rd        = 5'(wbq[0].rd);
      WB_i_gpr_alloc = wbq[0].ga;
      WB_i_csr_rd    = 3'(wbq[0].csr);
      WB_i_csr_alloc = wbq[0].ca;
    end else begin
      WB_i_release   = 1'b0;
      WB_i_rd        = 5'($urandom_range(31));
      WB_i_gpr_alloc = 1'($urandom_range(1));
      WB_i_csr_rd    = 3'($urandom_range(7));
      WB_i_csr_alloc = 1'($urandom_range(1));
    end
    @(negedge clk);
    e_raw = (IDU_i_rs1_used && IDU_i_rs1 != 0 && gm[IDU_i_rs1] != 0) ||
            (IDU_i_rs2_used && IDU_i_rs2 != 0 && gm[IDU_i_rs2] != 0) ||
            (IDU_i_csr_read && cm[IDU_i_csr_rs] != 0);
    e_sat = (IDU_i_write_gpr && IDU_i_rd != 0 && gm[IDU_i_rd] == MAXC) ||
            (IDU_i_write_csr && cm[IDU_i_csr_rd] == MAXC);
    e_free  = !vm || EXU_i_ready;
    e_issue = IFU_o_valid && !e_raw && !e_sat && e_free && !EXU_i_flush;
    e_ready = e_issue || !IFU_o_valid || EXU_i_flush;
    e_stall = IFU_o_valid && !e_issue && !EXU_i_flush;
    e_busy  = 1'b0;
    bad     = 0;
    for (int i = 0; i < 32; i++) begin
      if (gm[i] != 0) e_busy = 1'b1;
      if (int'(dut.gcnt_q[i]) != gm[i]) bad++;
    end
    for (int i = 0; i < 8; i++) begin
      if (cm[i] != 0) e_busy = 1'b1;
      if (int'(dut.ccnt_q[i]) != cm[i]) bad++;
    end
    chk("issue", int'(IDU_o_issue), int'(e_issue));
    chk("ready", int'(IDU_o_ready), int'(e_ready));
    chk("stall", int'(IDU_o_stall), int'(e_stall));
    chk("valid", int'(IDU_o_valid), int'(vm));
    chk("busy",  int'(IDU_o_busy),  int'(e_busy));
    chk("counter_mismatches", bad, 0);
    s_issue = int'(IDU_o_issue);
    s_stall = int'(IDU_o_stall);
    s_ready = int'(IDU_o_ready);
    @(posedge clk);
    if (rst) begin
      foreach (gm[i]) gm[i] = 0;
      foreach (cm[i]) cm[i] = 0;
      vm = 1'b0;
      wbq.delete();
    end else begin
      if (WB_i_release) begin
        r = wbq.pop_front();
        if (r.ga) gm[r.rd]--;
        if (r.ca) cm[r.csr]--;
      end
      if (EXU_i_flush) begin
        if (vm && slot_m.ga) gm[slot_m.rd]--;
        if (vm && slot_m.ca) cm[slot_m.csr]--;
        vm = 1'b0;
      end else if (e_free) begin
        if (vm) wbq.push_back(slot_m);
        vm = e_issue;
        if (e_issue) begin
          slot_m.rd  = int'(IDU_i_rd);
          slot_m.ga  = IDU_i_write_gpr && IDU_i_rd != 0;
          slot_m.csr = int'(IDU_i_csr_rd);
          slot_m.ca  = IDU_i_write_csr;
          if (slot_m.ga) gm[slot_m.rd]++;
          if (slot_m.ca) cm[slot_m.csr]++;
        end
      end
      bad = 0;
      foreach (gm[i]) if (gm[i] < 0 || gm[i] > MAXC) bad++;
      foreach (cm[i]) if (cm[i] < 0 || cm[i] > MAXC) bad++;
      chk("protocol_range", bad, 0);
    end
    #1;
  endtask

  task automatic drain();
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EXU_i_ready = 1'b1;
    EXU_i_flush = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (wbq.size() == 0 && !vm) break;
      step(1);
    end
    chk("drain_empty", wbq.size() + int'(vm), 0);
  endtask

  initial begin
    foreach (gm[i]) gm[i] = 0;
    foreach (cm[i]) cm[i] = 0;
    vm = 1'b0;
    rst = 1'b1;
    EXU_i_ready = 1'b1;
    EXU_i_flush = 1'b0;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    step(0);
    step(0);
    rst = 1'b0;
    chk("rst_valid", int'(IDU_o_valid), 0);
    chk("rst_busy",  int'(IDU_o_busy),  0);
    chk("rst_issue", int'(IDU_o_issue), 0);
    chk("rst_stall", int'(IDU_o_stall), 0);
    chk("rst_ready", int'(IDU_o_ready), 1);

    // back-to-back independent writes to x1..x4
    for (int k = 1; k <= 4; k++) begin
      set_ins(1, 0, 0, 0, 0, k, 1, 0, 0, 0, 0);
      step(0);
      chk("b2b_issue", s_issue, 1);
    end
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0);
    for (int k = 1; k <= 4; k++) lit_g("b2b_gcnt", k, 1);
    drain();

    // RAW on x5
    set_ins(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    step(0);
    chk("raw_first_issue", s_issue, 1);
    set_ins(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0);
    step(0);
    chk("raw_stall_a", s_stall, 1);
    step(0);
    chk("raw_stall_b", s_stall, 1);
    step(1);
    chk("raw_stall_at_release", s_stall, 1);
    lit_g("raw_g5_released", 5, 0);
    step(0);
    chk("raw_issue_after_release", s_issue, 1);
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0);
    lit_g("raw_g6", 6, 1);
    drain();

    // saturation on x7
    for (int k = 0; k < 3; k++) begin
      set_ins(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
      step(0);
      chk("sat_fill_issue", s_issue, 1);
    end
    step(0);
    chk("sat_stall", s_stall, 1);
    lit_g("sat_g7_full", 7, 3);
    step(1);
    chk("sat_stall_at_release", s_stall, 1);
    step(0);
    chk("sat_issue_after_release", s_issue, 1);
    lit_g("sat_g7_refill", 7, 3);
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1);
    lit_g("sat_g7_two", 7, 2);
    set_ins(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    step(1);
    chk("sat_issue_with_release", s_issue, 1);
    lit_g("sat_g7_same_edge", 7, 2);
    drain();

    // CSR hazards
    set_ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    step(0);
    chk("csr_write_issue", s_issue, 1);
    set_ins(1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
    step(0);
    chk("csr_read_slot2_stall", s_stall, 1);
    set_ins(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
    step(0);
    chk("csr_read_slot3_issue", s_issue, 1);
    drain();

    // flush with a held slot
    set_ins(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    step(0);
    EXU_i_ready = 1'b0;
    set_ins(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0);
    step(0);
    chk("flush_backpressure_stall", s_stall, 1);
    lit_g("flush_g9_held", 9, 1);
    EXU_i_flush = 1'b1;
    step(0);
    chk("flush_no_issue", s_issue, 0);
    chk("flush_ready", s_ready, 1);
    chk("flush_valid_cleared", int'(IDU_o_valid), 0);
    EXU_i_flush = 1'b0;
    EXU_i_ready = 1'b1;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0);
    lit_g("flush_g9", 9, 0);
    lit_g("flush_g10", 10, 0);
    drain();

    // x0 never counted, never a hazard
    set_ins(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0);
    chk("x0_write_issue", s_issue, 1);
    set_ins(1, 0, 1, 0, 1, 11, 0, 0, 0, 0, 0);
    step(0);
    chk("x0_read_issue", s_issue, 1);
    lit_g("x0_gcnt", 0, 0);
    chk("x0_not_busy", int'(IDU_o_busy), 0);
    drain();

    // reset mid-operation with gcnt[3]=2 and a pending release
    set_ins(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    step(0);
    step(0);
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0);
    lit_g("rst_mid_g3", 3, 2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_mid_busy", int'(IDU_o_busy), 0);
    chk("rst_mid_valid", int'(IDU_o_valid), 0);
    lit_g("rst_mid_g3_clear", 3, 0);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      set_ins(($urandom_range(9) < 7),
              $urandom_range(7), 1'($urandom_range(1)),
              $urandom_range(7), 1'($urandom_range(1)),
              $urandom_range(7), 1'($urandom_range(1)),
              $urandom_range(3), ($urandom_range(3) == 0),
              $urandom_range(3), ($urandom_range(3) == 0));
      EXU_i_ready = ($urandom_range(3) != 0);
      EXU_i_flush = ($urandom_range(11) == 0);
      rst         = ($urandom_range(199) == 0);
      step(1'($urandom_range(1)));
    end
    rst = 1'b0;
    EXU_i_flush = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
